// File: rtl/negate_seq_pkg.sv
// negate_seq_pkg: shared FSM encoding and sizing helper for negate_seq
package negate_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_bits(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/negate_seq_ones.sv
// ones: bitwise ones' complement of a chunk
module ones #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = ~a;
endmodule

// File: rtl/negate_seq.sv
// negate_seq: serial two's-complement negate/pass, CHUNK bits per cycle, LSB first
module negate_seq
   import negate_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);
   localparam int N = WIDTH / CHUNK;
   localparam int CW = cnt_bits(N);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   state_t state, nxt;
   logic [WIDTH-1:0] sr;
   logic carry, neg, ovf, last;
   logic [CW-1:0] cnt;
   logic [CHUNK-1:0] inv, opnd;
   logic [CHUNK:0] sum;
   ones #(.WIDTH(CHUNK)) u_ones (.a(sr[CHUNK-1:0]), .y(inv));
   assign opnd = neg ? inv : sr[CHUNK-1:0];
   assign sum = {1'b0, opnd} + {{CHUNK{1'b0}}, carry};
   assign last = cnt == CW'(N - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         carry <= 1'b0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && in_valid) begin
            sr    <= in_data;
            carry <= in_neg;
            neg   <= in_neg;
            ovf   <= in_neg && in_data == MOST_NEG;
            cnt   <= '0;
         end else if (state == RUN) begin
            // sum chunk enters at the top as the low chunk shifts out
            sr    <= WIDTH'({sum[CHUNK-1:0], sr} >> CHUNK);
            carry <= sum[CHUNK];
            cnt   <= cnt + CW'(1);
         end
      end
   end
   always_comb begin
      nxt = (state == IDLE && in_valid)  ? RUN  :
            (state == RUN && last)       ? DONE :
            (state == DONE && out_ready) ? IDLE : state;
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      out_data  = out_valid ? sr : '0;
      out_ovf   = out_valid & ovf;
   end
endmodule
